vram_slot_scheduler: RTL

- Decides which non-display requester owns each free VRAM access slot in the VDP: CPU write, CPU read or VDP command engine.
- Runs in the CLK21M domain alongside the VRAM address bus mux.
- Uses toggle req/ack handshakes and issues one registered grant per free slot.
- CPU requests normally win; a starvation counter guarantees the command engine forward progress.

---
 rtl/vram_slot_scheduler.sv | 110 +++++++++++
 1 files changed

// File: rtl/vram_slot_scheduler.sv
// Arbitrates free VRAM slots among CPU write, CPU read and the command engine.
// Toggle req/ack handshakes; one registered grant per decision edge; starvation boost for commands.
module vram_slot_scheduler #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic             CLK21M,
  input  logic             RESET,
  input  logic [1:0]       DOTSTATE,
  input  logic             slot_open,
  input  logic             cpu_wr_req,
  input  logic             cpu_rd_req,
  input  logic             cmd_active,
  input  logic             cmd_req,
  output logic             cpu_wr_ack,
  output logic             cpu_rd_ack,
  output logic             cmd_ack,
  output logic [1:0]       grant,
  output logic             grant_valid,
  output logic [CNT_W-1:0] cmd_wait_cnt,
  output logic             cmd_boosted
);

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_WR   = 2'b01,
    GNT_RD   = 2'b10,
    GNT_CMD  = 2'b11
  } grant_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] LIMIT_VAL = CNT_W'(STARVE_LIMIT);

  logic             wr_ack_reg, wr_ack_next;
  logic             rd_ack_reg, rd_ack_next;
  logic             cmd_ack_reg, cmd_ack_next;
  grant_t           grant_reg, grant_next;
  logic             grant_valid_reg, grant_valid_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             boosted_reg, boosted_next;

  logic   decide;
  logic   pw, pr, pc;
  grant_t winner;

  assign decide = (DOTSTATE == 2'b10) && slot_open;
  assign pw     = cpu_wr_req ^ wr_ack_reg;
  assign pr     = cpu_rd_req ^ rd_ack_reg;
  // A stale toggle from an aborted command is masked while the engine is idle.
  assign pc     = cmd_active & (cmd_req ^ cmd_ack_reg);

  always_comb begin
    winner           = GNT_NONE;
    wr_ack_next      = wr_ack_reg;
    rd_ack_next      = rd_ack_reg;
    cmd_ack_next     = cmd_ack_reg;
    cnt_next         = cnt_reg;
    if (decide) begin
      if (pc && boosted_reg) winner = GNT_CMD;
      else if (pw)           winner = GNT_WR;
      else if (pr)           winner = GNT_RD;
      else if (pc)           winner = GNT_CMD;
    end
    case (winner)
      GNT_WR:  wr_ack_next  = ~wr_ack_reg;
      GNT_RD:  rd_ack_next  = ~rd_ack_reg;
      GNT_CMD: cmd_ack_next = ~cmd_ack_reg;
      default: ;
    endcase
    grant_next       = winner;
    grant_valid_next = (winner != GNT_NONE);
    // Counter tracks consecutive decision slots lost by a pending command.
    if (!cmd_active)
      cnt_next = '0;
    else if (decide) begin
      if (winner == GNT_CMD || !pc) cnt_next = '0;
      else if (cnt_reg != CNT_MAX)  cnt_next = cnt_reg + CNT_W'(1);
    end
    boosted_next = (cnt_next >= LIMIT_VAL);
  end

  always_ff @(posedge CLK21M or posedge RESET) begin
    if (RESET) begin
      wr_ack_reg      <= 1'b0;
      rd_ack_reg      <= 1'b0;
      cmd_ack_reg     <= 1'b0;
      grant_reg       <= GNT_NONE;
      grant_valid_reg <= 1'b0;
      cnt_reg         <= '0;
      boosted_reg     <= 1'b0;
    end else begin
      wr_ack_reg      <= wr_ack_next;
      rd_ack_reg      <= rd_ack_next;
      cmd_ack_reg     <= cmd_ack_next;
      grant_reg       <= grant_next;
      grant_valid_reg <= grant_valid_next;
      cnt_reg         <= cnt_next;
      boosted_reg     <= boosted_next;
    end
  end

  assign cpu_wr_ack   = wr_ack_reg;
  assign cpu_rd_ack   = rd_ack_reg;
  assign cmd_ack      = cmd_ack_reg;
  assign grant        = grant_reg;
  assign grant_valid  = grant_valid_reg;
  assign cmd_wait_cnt = cnt_reg;
  assign cmd_boosted  = boosted_reg;

endmodule
